// File: rtl/cordic_engine_iter.sv
// Iterative fixed-point CORDIC engine: one micro-rotation per clock, quadrant
// pre-rotation up front, results saturated to WIDTH bits and registered with done.
module cordic_engine_iter #(
  parameter int WIDTH      = 32,
  parameter int FRAC       = 29,
  parameter int ITERATIONS = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out,
  output logic             busy,
  output logic             done,
  output logic             sat
);

  localparam int DW = WIDTH + 2;
  localparam int SH = 30 - FRAC;
  localparam logic [4:0] LAST = 5'(ITERATIONS - 1);

  // pi/2 in Q.60, rounded half-up to FRAC bits
  localparam logic [63:0] HPI_Q60 = 64'h1921FB54442D1846;
  localparam logic [63:0] HPI_R   = (HPI_Q60 + (64'd1 << (59 - FRAC))) >> (60 - FRAC);
  localparam logic signed [DW-1:0] HPI = $signed(HPI_R[DW-1:0]);

  typedef enum logic [1:0] {IDLE, PRE, ITER, POST} state_e;

  state_e                state_q;
  logic signed [DW-1:0]  x_q, y_q, z_q;
  logic [4:0]            it_q;
  logic                  mode_q;
  logic [WIDTH-1:0]      xo_q, yo_q, zo_q;
  logic                  busy_q, done_q, sat_q;

  logic signed [DW-1:0]  xp, yp, zp, xn, yn, zn, sh_x, sh_y, ang;
  logic                  dpos, accept;
  logic [WIDTH:0]        sx, sy, sz;

  // atan(2^-i) in Q2.30, rounded, then rescaled to FRAC with round-half-up
  function automatic logic signed [DW-1:0] atan_lut(input logic [4:0] i);
    logic [31:0] t;
    logic [32:0] r;
    case (i)
      5'd0:    t = 32'h3243F6A9;
      5'd1:    t = 32'h1DAC6705;
      5'd2:    t = 32'h0FADBAFD;
      5'd3:    t = 32'h07F56EA7;
      5'd4:    t = 32'h03FEAB77;
      5'd5:    t = 32'h01FFD55C;
      5'd6:    t = 32'h00FFFAAB;
      5'd7:    t = 32'h007FFF55;
      5'd8:    t = 32'h003FFFEB;
      5'd9:    t = 32'h001FFFFD;
      5'd10:   t = 32'h00100000;
      5'd11:   t = 32'h00080000;
      5'd31:   t = 32'h00000000;
      default: t = 32'd1 << (5'd30 - i);
    endcase
    r = {1'b0, t} + (33'd1 << (SH - 1));
    return DW'(r >> SH);
  endfunction

  // {overflow, clamped value}; in range when the three top bits agree
  function automatic logic [WIDTH:0] satw(input logic signed [DW-1:0] v);
    if (v[DW-1:WIDTH-1] == {3{v[DW-1]}}) return {1'b0, v[WIDTH-1:0]};
    else if (v[DW-1])                    return {2'b11, {(WIDTH-1){1'b0}}};
    else                                 return {2'b10, {(WIDTH-1){1'b1}}};
  endfunction

  always_comb begin
    xp = x_q;
    yp = y_q;
    zp = z_q;
    if (!mode_q) begin
      if (z_q > HPI) begin
        xp = -y_q; yp = x_q;  zp = z_q - HPI;
      end else if (z_q < -HPI) begin
        xp = y_q;  yp = -x_q; zp = z_q + HPI;
      end
    end else if (x_q[DW-1]) begin
      if (!y_q[DW-1]) begin
        xp = y_q;  yp = -x_q; zp = z_q + HPI;
      end else begin
        xp = -y_q; yp = x_q;  zp = z_q - HPI;
      end
    end
  end

  always_comb begin
    sh_x = x_q >>> it_q;
    sh_y = y_q >>> it_q;
    ang  = atan_lut(it_q);
    dpos = mode_q ? y_q[DW-1] : ~z_q[DW-1];
    if (dpos) begin
      xn = x_q - sh_y; yn = y_q + sh_x; zn = z_q - ang;
    end else begin
      xn = x_q + sh_y; yn = y_q - sh_x; zn = z_q + ang;
    end
    sx = satw(xn);
    sy = satw(yn);
    sz = satw(zn);
  end

  // POST is the done cycle, so a start there is taken like one in IDLE
  assign accept = start && (state_q == IDLE || state_q == POST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      it_q    <= '0;
      mode_q  <= 1'b0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        x_q     <= {{2{x_in[WIDTH-1]}}, x_in};
        y_q     <= {{2{y_in[WIDTH-1]}}, y_in};
        z_q     <= {{2{z_in[WIDTH-1]}}, z_in};
        mode_q  <= mode;
        busy_q  <= 1'b1;
        sat_q   <= 1'b0;
        state_q <= PRE;
      end else begin
        case (state_q)
          PRE: begin
            x_q     <= xp;
            y_q     <= yp;
            z_q     <= zp;
            it_q    <= '0;
            state_q <= ITER;
          end
          ITER: begin
            x_q  <= xn;
            y_q  <= yn;
            z_q  <= zn;
            it_q <= it_q + 5'd1;
            // final micro-rotation feeds the saturating output registers directly
            if (it_q == LAST) begin
              xo_q    <= sx[WIDTH-1:0];
              yo_q    <= sy[WIDTH-1:0];
              zo_q    <= sz[WIDTH-1:0];
              sat_q   <= sx[WIDTH] | sy[WIDTH] | sz[WIDTH];
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= POST;
            end
          end
          POST:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign x_out = xo_q;
  assign y_out = yo_q;
  assign z_out = zo_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sat   = sat_q;

endmodule

// File: doc/cordic_engine_iter.md
Name: cordic_engine_iter

Overview:
- Parametrised iterative fixed-point CORDIC core with a start/done handshake.
- Serves as the shared trigonometric back-end for the floating-point custom-instruction tops; the float-to-fixed and fixed-to-float converters sit outside this block.
- Supports rotation mode (sin/cos, vector rotate) and vectoring mode (magnitude/atan2).
- Width, fraction bits and iteration count are configurable.
- Adds quadrant pre-rotation and output saturation.

Parameters:
- WIDTH, 32, operand/result width in bits, signed two's complement; legal range 16..32.
- FRAC, 29, fraction bits for x, y and z, giving Q(WIDTH-FRAC).FRAC format; z is in radians; requires WIDTH-FRAC >= 3.
- ITERATIONS, 24, micro-rotations per operation; legal range 8..WIDTH-2.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only when busy=0
- mode  in  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0)
- x_in  in  WIDTH  signed x operand
- y_in  in  WIDTH  signed y operand
- z_in  in  WIDTH  signed angle operand, radians
- x_out  out  WIDTH  signed x result, registered
- y_out  out  WIDTH  signed y result, registered
- z_out  out  WIDTH  signed z result, registered
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; results valid
- sat  out  1  high with done if any result saturated; held until the next accepted start

Behaviour:
- Reset: while reset_n=0, all outputs are 0 and the state is IDLE, asynchronously. Reset mid-operation abandons the operation and no done is produced.
- Interface timing: reset is the only asynchronous path. There are no combinational paths from inputs to outputs.
- States:
  - IDLE -> PRE on start.
  - PRE -> ITER after 1 cycle.
  - ITER -> POST after ITERATIONS cycles.
  - POST -> IDLE after 1 cycle, asserting done.
- Latency: start sampled high at edge T gives done high during cycle T+ITERATIONS+2.
- Throughput: busy is low again in the cycle done is high. A start in that same cycle is accepted, so back-to-back operations are possible.
- Start while busy=1 is ignored and has no effect on the running operation.
- Operand capture: x_in, y_in, z_in and mode are captured at the accepting edge. Later input changes are ignored.
- Internal datapath: x, y and z are held at WIDTH+2 bits, sign-extended, to absorb CORDIC gain growth.
- PRE, rotation mode:
  - If z > pi/2: (x,y,z) <- (-y, x, z - pi/2).
  - If z < -pi/2: (x,y,z) <- (y, -x, z + pi/2).
  - Otherwise pass through.
- PRE, vectoring mode:
  - If x < 0 and y >= 0: (x,y,z) <- (y, -x, z + pi/2).
  - If x < 0 and y < 0: (x,y,z) <- (-y, x, z - pi/2).
  - The pi/2 constant is rounded to FRAC bits.
- ITER step i (0..ITERATIONS-1):
  - Direction d = +1 if (rotation and z >= 0) or (vectoring and y < 0), else -1.
  - x <- x - d*(y >>> i); y <- y + d*(x >>> i); z <- z - d*atan(2^-i).
  - Shifts are arithmetic.
- Angle table: internal 32-entry table of atan(2^-i) in Q2.30, rounded. Entries are scaled to FRAC by an arithmetic right shift of (30-FRAC) with round-half-up.
- Gain: no gain compensation. Results carry K ≈ 1.646760; the caller pre-scales x_in/y_in by 1/K where required.
- POST, saturation: each of x, y and z is saturated to WIDTH bits. Overflow above the positive limit gives 0x7FF..F; below the negative limit gives 0x800..0. sat is set if any of the three saturated.
- Result hold: x_out, y_out, z_out and sat update only at the POST edge and hold until the next POST or reset.
- busy and done are never high in the same cycle, except that busy may be high alongside done when a new start is accepted in the done cycle.

Test Plan (WIDTH=32, FRAC=29, ITERATIONS=24; tolerance ±64 LSB unless stated):
- Rotation, x=0x136E9DB5 (1/K), y=0, z=0, start pulse -> done at T+26; x_out≈0x20000000, y_out≈0, z_out≈0, sat=0; busy high for exactly 25 cycles.
- Rotation, x=0x136E9DB5, y=0, z=0x3243F6A9 (pi/2) -> x_out≈0, y_out≈0x20000000. Repeat with z=0xCDBC0957 (-pi/2) -> y_out≈0xE0000000. Also covers the pre-rotation boundary.
- Vectoring, x=y=0x10000000 (0.5) -> z_out≈0x1921FB54 (pi/4), y_out≈0, x_out≈1.16443·2^29 within 2^-20. Repeat with x=0xF0000000 (-0.5), y=0x10000000 -> z_out≈3pi/4 (0x4B65F1FD).
- Saturation: rotation, x=y=0x7C000000 (3.875), z=pi/4 -> y_out=0x7FFFFFFF, sat=1 with done. A following in-range operation clears sat.
- Handshake: start during busy with different operands -> ignored, result matches the first operands. start in the done cycle -> accepted, second done exactly 26 cycles after the first.
- Reset: drop reset_n at cycle 10 of an operation -> busy, done, sat and results go to 0 immediately; no done after release. A fresh start completes normally.
